ga_issue_unit: RTL and testbench
================================

GA_ISSUE_UNIT -- requirements
Module: ga_issue_unit

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 1024: WAIT-state cycles before abandoning a request; legal range 2..65535.
REQ-002 SHALL have the following ports; reset is asynchronous and active-high on rst_i; one clock clk_i.
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- issue_valid_i  in  1  core presents GA instruction.
- issue_ready_o  out  1  unit accepts instruction.
- issue_funct_i  in  ga_funct_e  operation.
- issue_operand_a_i / issue_operand_b_i  in  ga_multivector_t  immediate operands.
- issue_reg_a_i / issue_reg_b_i / issue_rd_i  in  5  GA register addresses.
- issue_we_i  in  1  write result to GA register file.
- issue_use_ga_regs_i  in  1  source operands from GA registers.
- ga_req_o  out  ga_req_t  request to coprocessor.
- ga_resp_i  in  ga_resp_t  response from coprocessor.
- wb_valid_o  out  1  result available to core.
- wb_ready_i  in  1  core consumes result.
- wb_result_o  out  ga_multivector_t  captured result.
- wb_error_o  out  1  coprocessor error or timeout.
- wb_timeout_o  out  1  result caused by timeout.
- busy_o  out  1  state not IDLE.

Function
REQ-003 SHALL implement FSM IDLE, SEND, WAIT, DONE; single outstanding request.
REQ-004 IDLE: issue_ready_o=1 only when ga_resp_i.valid=0 (drain rule); on issue_valid_i&&issue_ready_o SHALL register all issue fields into ga_req_o payload and go to SEND.
REQ-005 SEND: ga_req_o.valid=1; on ga_resp_i.ready=1 same cycle go to WAIT; otherwise hold valid and payload stable.
REQ-006 ga_req_o.valid SHALL be 1 only in SEND; payload SHALL hold the last accepted instruction in all states.
REQ-007 WAIT: on ga_resp_i.valid=1 SHALL capture result and error into wb registers and go to DONE; ga_resp_i.busy ignored.
REQ-008 ga_resp_i.valid in IDLE, SEND or DONE SHALL be ignored (no capture, no state change).
REQ-009 DONE: wb_valid_o=1 with result stable; on wb_ready_i=1 go to IDLE; wb_valid_o SHALL not drop until consumed.
REQ-010 Minimum latency: instruction accepted cycle N, ga_req_o.valid cycle N+1, response at cycle M, wb_valid_o at M+1.
REQ-011 busy_o SHALL equal (state != IDLE).
REQ-012 ga_resp_i.overflow/underflow SHALL be ORed into wb_error_o.

Reset
REQ-013 On rst_i SHALL enter IDLE asynchronously, mid-transaction included; ga_req_o all zero, wb_valid_o=0, wb_result_o=0, wb_error_o=0, wb_timeout_o=0, busy_o=0, timeout counter 0.
REQ-014 After reset deassertion issue_ready_o SHALL follow REQ-004 from the first clock edge.

Configuration
REQ-015 With GA_ISSUE_TIMEOUT_EN defined: a counter SHALL clear on WAIT entry and increment each WAIT cycle; when it reaches TimeoutCycles without response, go to DONE with wb_result_o=0, wb_error_o=1, wb_timeout_o=1.
REQ-016 A response arriving in the same cycle as the timeout SHALL win (normal capture, wb_timeout_o=0).
REQ-017 Without GA_ISSUE_TIMEOUT_EN: no counter, WAIT is unbounded, wb_timeout_o tied 0.

Structure
REQ-018 ga_funct_e, ga_multivector_t, ga_req_t and ga_resp_t SHALL come from ga_pkg; no new package types; state enum local.
REQ-019 SHALL be a single flat module, no sub-module.

Verification
REQ-020 Basic ADD: issue funct=ADD, A=1.0 scalar, B=2.0 scalar; responder replies valid after 4 cycles -> ga_req_o.valid one cycle at N+1, wb_valid_o at response+1, wb_result_o=3.0, wb_error_o=0.
REQ-021 Backpressure: responder ready=0 for 3 cycles -> ga_req_o held with unchanged payload 4 cycles; wb_valid_o held 5 cycles with wb_ready_i=0, result stable.
REQ-022 Error: responder returns valid with error=1 -> wb_error_o=1, wb_timeout_o=0.
REQ-023 Timeout (macro on, TimeoutCycles=8): no response -> DONE after 8 WAIT cycles, wb_error_o=1, wb_timeout_o=1; late response in IDLE is ignored and blocks issue_ready_o while high.
REQ-024 Reset mid-WAIT: assert rst_i -> all outputs zero immediately; the next instruction completes normally.
REQ-025 Back-to-back: two instructions with responder holding valid 2 cycles -> exactly two wb results, second request not issued until ga_resp_i.valid low.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared geometric-algebra types for the GA coprocessor interface.
// Multivector coefficients are Q8.8 fixed point (1.0 = 16'h0100).
package ga_pkg;

  typedef enum logic [3:0] {
    GA_ADD   = 4'd0,
    GA_SUB   = 4'd1,
    GA_GP    = 4'd2,
    GA_WEDGE = 4'd3,
    GA_DOT   = 4'd4,
    GA_REV   = 4'd5
  } ga_funct_e;

  typedef struct packed {
    logic [15:0] e123;
    logic [15:0] e23;
    logic [15:0] e31;
    logic [15:0] e12;
    logic [15:0] e3;
    logic [15:0] e2;
    logic [15:0] e1;
    logic [15:0] s;
  } ga_multivector_t;

  typedef struct packed {
    logic            valid;
    ga_funct_e       funct;
    ga_multivector_t operand_a;
    ga_multivector_t operand_b;
    logic [4:0]      reg_a;
    logic [4:0]      reg_b;
    logic [4:0]      rd;
    logic            we;
    logic            use_ga_regs;
  } ga_req_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic            busy;
    ga_multivector_t result;
    logic            error;
    logic            overflow;
    logic            underflow;
  } ga_resp_t;

  localparam logic [15:0] GA_ONE = 16'h0100;

endpackage

// File: rtl/ga_issue_unit.sv
// GA issue unit: accepts one GA instruction from the core, forwards it to
// the coprocessor, waits for the response and holds it for writeback.
// Ports: clk_i/rst_i (async active-high); issue_* core side instruction;
// ga_req_o/ga_resp_i coprocessor link; wb_* result to core; busy_o.
// Optional macro GA_ISSUE_TIMEOUT_EN bounds WAIT to TimeoutCycles cycles.
module ga_issue_unit
  import ga_pkg::*;
#(
  parameter int TimeoutCycles = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  ga_funct_e       issue_funct_i,
  input  ga_multivector_t issue_operand_a_i,
  input  ga_multivector_t issue_operand_b_i,
  input  logic [4:0]      issue_reg_a_i,
  input  logic [4:0]      issue_reg_b_i,
  input  logic [4:0]      issue_rd_i,
  input  logic            issue_we_i,
  input  logic            issue_use_ga_regs_i,
  output ga_req_t         ga_req_o,
  input  ga_resp_t        ga_resp_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output ga_multivector_t wb_result_o,
  output logic            wb_error_o,
  output logic            wb_timeout_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic            w_accept;
  logic            w_capture;
  logic            w_timeout;
  ga_req_t         r_req;
  ga_multivector_t r_result;
  logic            r_error;
  logic            w_unused;

`ifdef GA_ISSUE_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TimeoutCycles - 1);
  logic [15:0] r_cnt;
  logic        r_timeout;
`endif

  // busy of the response is informational only
  assign w_unused = ga_resp_i.busy ^ (TimeoutCycles == 0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_timeout     = 1'b0;
    issue_ready_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // stale responses must drain before a new request goes out
        issue_ready_o = !ga_resp_i.valid;
        if (issue_valid_i && !ga_resp_i.valid) begin
          w_accept = 1'b1;
          w_next   = S_SEND;
        end
      end
      S_SEND: begin
        if (ga_resp_i.ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        // a response in the timeout cycle takes priority
        if (ga_resp_i.valid) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
`ifdef GA_ISSUE_TIMEOUT_EN
        else if (r_cnt == LP_TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (wb_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req    <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req.valid       <= 1'b0;
        r_req.funct       <= issue_funct_i;
        r_req.operand_a   <= issue_operand_a_i;
        r_req.operand_b   <= issue_operand_b_i;
        r_req.reg_a       <= issue_reg_a_i;
        r_req.reg_b       <= issue_reg_b_i;
        r_req.rd          <= issue_rd_i;
        r_req.we          <= issue_we_i;
        r_req.use_ga_regs <= issue_use_ga_regs_i;
      end
      if (w_capture) begin
        r_result <= ga_resp_i.result;
        r_error  <= ga_resp_i.error
                  | ga_resp_i.overflow
                  | ga_resp_i.underflow;
      end else if (w_timeout) begin
        r_result <= '0;
        r_error  <= 1'b1;
      end
    end
  end

`ifdef GA_ISSUE_TIMEOUT_EN
  // held at zero outside WAIT, so it restarts on every WAIT entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  r_cnt <= '0;
    else if (r_state != S_WAIT) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_timeout <= 1'b0;
    else if (w_capture) r_timeout <= 1'b0;
    else if (w_timeout) r_timeout <= 1'b1;
  end

  assign wb_timeout_o = r_timeout;
`else
  assign wb_timeout_o = 1'b0;
`endif

  always_comb begin
    ga_req_o       = r_req;
    ga_req_o.valid = (r_state == S_SEND);
  end

  assign wb_valid_o  = (r_state == S_DONE);
  assign wb_result_o = r_result;
  assign wb_error_o  = r_error;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ga_issue_unit.sv
// Self-checking bench for ga_issue_unit: table vectors, random
// transactions against a coprocessor model, and corner sequences.
module tb_ga_issue_unit;
  import ga_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic            issue_ready;
  ga_funct_e       funct;
  ga_multivector_t opa, opb;
  logic [4:0]      reg_a, reg_b, rd;
  logic            we, use_regs;
  ga_req_t         ga_req;
  ga_resp_t        ga_resp;
  logic            wb_valid, wb_ready;
  ga_multivector_t wb_result;
  logic            wb_error, wb_timeout, busy;

  int nvec = 0;
  int nerr = 0;
  int n_wb = 0;
  ga_multivector_t last_r;

  always #5 clk = ~clk;

  ga_issue_unit #(.TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_funct_i(funct),
    .issue_operand_a_i(opa), .issue_operand_b_i(opb),
    .issue_reg_a_i(reg_a), .issue_reg_b_i(reg_b), .issue_rd_i(rd),
    .issue_we_i(we), .issue_use_ga_regs_i(use_regs),
    .ga_req_o(ga_req), .ga_resp_i(ga_resp),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_result_o(wb_result), .wb_error_o(wb_error),
    .wb_timeout_o(wb_timeout), .busy_o(busy)
  );

  always @(posedge clk) if (wb_valid && wb_ready) n_wb++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    ga_funct_e       f;
    ga_multivector_t a, b;
    int              stall, delay, hold;
    logic            er, ov, un;
    ga_multivector_t exp_r;
    logic            exp_e;
  } vec_t;

  task automatic chk(input string nm, input logic [319:0] act,
                     input logic [319:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ga_multivector_t mv(logic [15:0] s, logic [15:0] e1,
                                          logic [15:0] e12);
    ga_multivector_t m;
    m = '0; m.s = s; m.e1 = e1; m.e12 = e12;
    return m;
  endfunction

  function automatic ga_multivector_t rnd_mv();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // coprocessor model: coefficient-wise add/subtract modulo 2^16
  function automatic ga_multivector_t model_op(ga_funct_e f,
      ga_multivector_t a, ga_multivector_t b);
    logic [7:0][15:0] pa, pb, pr;
    pa = a; pb = b;
    for (int i = 0; i < 8; i++)
      pr[i] = (f == GA_SUB) ? pa[i] - pb[i] : pa[i] + pb[i];
    return pr;
  endfunction

  function automatic vec_t mk(ga_funct_e f, ga_multivector_t a,
      ga_multivector_t b, int st, int dl, int hd, logic er, logic ov,
      logic un, ga_multivector_t xr, logic xe);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.stall = st; v.delay = dl; v.hold = hd;
    v.er = er; v.ov = ov; v.un = un; v.exp_r = xr; v.exp_e = xe;
    return v;
  endfunction

  task automatic clr_resp();
    ga_resp = '0;
  endtask

  // drive one instruction through SEND; ends at first WAIT negedge
  task automatic start_txn(input ga_funct_e f, input ga_multivector_t a,
                           input ga_multivector_t b, input int stall);
    logic [276:0] pay;
    funct = f; opa = a; opb = b;
    reg_a = 5'($urandom); reg_b = 5'($urandom); rd = 5'($urandom);
    we = 1'($urandom); use_regs = 1'($urandom);
    pay = {f, a, b, reg_a, reg_b, rd, we, use_regs};
    chk("ready_idle", issue_ready, 1'b1);
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    opa = rnd_mv(); opb = rnd_mv(); reg_a = 5'($urandom);
    chk("req_valid_n1", ga_req.valid, 1'b1);
    chk("req_payload", {ga_req.funct, ga_req.operand_a, ga_req.operand_b,
        ga_req.reg_a, ga_req.reg_b, ga_req.rd, ga_req.we,
        ga_req.use_ga_regs}, pay);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("req_hold_valid", ga_req.valid, 1'b1);
      chk("req_hold_opa", ga_req.operand_a, a);
    end
    ga_resp.ready = 1'b1;
    @(negedge clk);
    ga_resp.ready = 1'b0;
    chk("req_drop", ga_req.valid, 1'b0);
    chk("req_kept_opb", ga_req.operand_b, b);
    chk("busy_wait", busy, 1'b1);
  endtask

  task automatic respond(input ga_multivector_t r, input logic er,
                         input logic ov, input logic un);
    ga_resp.valid = 1'b1; ga_resp.result = r;
    ga_resp.error = er; ga_resp.overflow = ov; ga_resp.underflow = un;
    ga_resp.busy = 1'b1;
    @(negedge clk);
    clr_resp();
  endtask

  task automatic consume();
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("idle_after_wb", busy, 1'b0);
    chk("wb_drop", wb_valid, 1'b0);
  endtask

  task automatic run_txn(input vec_t v);
    start_txn(v.f, v.a, v.b, v.stall);
    for (int i = 0; i < v.delay; i++) begin
      chk("wait_no_wb", wb_valid, 1'b0);
      @(negedge clk);
    end
    respond(model_op(v.f, v.a, v.b), v.er, v.ov, v.un);
    chk("wb_valid_m1", wb_valid, 1'b1);
    chk("wb_result", wb_result, v.exp_r);
    chk("wb_error", wb_error, v.exp_e);
    chk("wb_timeout", wb_timeout, 1'b0);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("wb_hold_valid", wb_valid, 1'b1);
      chk("wb_hold_result", wb_result, v.exp_r);
    end
    consume();
    last_r = v.exp_r;
  endtask

  vec_t tbl[7];
  vec_t rv;
  int   base;

  initial begin
    tbl[0] = mk(GA_ADD, mv(GA_ONE, 0, 0), mv(16'h0200, 0, 0), 0, 4, 0,
                0, 0, 0, mv(16'h0300, 0, 0), 0);
    tbl[1] = mk(GA_SUB, mv(16'h0500, 16'h0200, 0), mv(GA_ONE, 16'h0080, 0),
                0, 1, 1, 0, 0, 0, mv(16'h0400, 16'h0180, 0), 0);
    tbl[2] = mk(GA_ADD, mv(0, 0, GA_ONE), mv(0, 0, GA_ONE), 3, 1, 5,
                0, 0, 0, mv(0, 0, 16'h0200), 0);
    tbl[3] = mk(GA_ADD, mv(GA_ONE, 0, 0), mv(GA_ONE, 0, 0), 0, 2, 0,
                1, 0, 0, mv(16'h0200, 0, 0), 1);
    tbl[4] = mk(GA_ADD, mv(16'h7f00, 0, 0), mv(16'h0200, 0, 0), 1, 0, 0,
                0, 1, 0, mv(16'h8100, 0, 0), 1);
    tbl[5] = mk(GA_SUB, mv(0, 16'h0001, 0), mv(0, 16'h0001, 0), 0, 3, 2,
                0, 0, 1, mv(0, 0, 0), 1);
    tbl[6] = mk(GA_SUB, mv(0, 0, 0), mv(GA_ONE, 0, 0), 0, 0, 0,
                0, 0, 0, mv(16'hff00, 0, 0), 0);

    rst = 1'b1; issue_valid = 1'b0; wb_ready = 1'b0;
    funct = GA_ADD; opa = '0; opb = '0; reg_a = '0; reg_b = '0; rd = '0;
    we = 1'b0; use_regs = 1'b0; clr_resp();
    @(negedge clk); @(negedge clk);
    chk("rst_req", ga_req, 278'd0);
    chk("rst_wb", {wb_valid, wb_result, wb_error, wb_timeout, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", issue_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // stray response while idle: ignored, and blocks issue
    ga_resp.valid = 1'b1; ga_resp.result = rnd_mv();
    issue_valid = 1'b1;
    #1 chk("drain_ready", issue_ready, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("drain_busy", busy, 1'b0);
    chk("drain_wb", wb_valid, 1'b0);
    chk("drain_result", wb_result, last_r);
    issue_valid = 1'b0; clr_resp();
    #1 chk("drain_release", issue_ready, 1'b1);
    @(negedge clk);

    // reset in the middle of WAIT
    start_txn(GA_ADD, mv(GA_ONE, 0, 0), mv(GA_ONE, 0, 0), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("arst_req", ga_req, 278'd0);
    chk("arst_wb", {wb_valid, wb_result, wb_error, wb_timeout, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(tbl[0]);

    // back-to-back with a lingering response
    base = n_wb;
    funct = GA_ADD; opa = mv(GA_ONE, 0, 0); opb = mv(GA_ONE, 0, 0);
    issue_valid = 1'b1;
    @(negedge clk);
    funct = GA_SUB; opa = mv(16'h0300, 0, 0); opb = mv(GA_ONE, 0, 0);
    ga_resp.ready = 1'b1;
    @(negedge clk);
    ga_resp.ready = 1'b0;
    ga_resp.valid = 1'b1; ga_resp.result = mv(16'h0200, 0, 0);
    @(negedge clk);
    chk("b2b_wb1", wb_result, mv(16'h0200, 0, 0));
    ga_resp.result = rnd_mv();
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("b2b_hold_ready", issue_ready, 1'b0);
    chk("b2b_hold_busy", busy, 1'b0);
    @(negedge clk);
    chk("b2b_no_send", ga_req.valid, 1'b0);
    clr_resp();
    @(negedge clk);
    issue_valid = 1'b0;
    chk("b2b_send2", ga_req.valid, 1'b1);
    chk("b2b_funct2", ga_req.funct, GA_SUB);
    ga_resp.ready = 1'b1;
    @(negedge clk);
    ga_resp.ready = 1'b0;
    respond(mv(16'h0200, 0, 0), 0, 0, 0);
    chk("b2b_wb2", wb_valid, 1'b1);
    consume();
    @(negedge clk);
    chk("b2b_count", n_wb - base, 2);

    // random transactions against the model
    for (int k = 0; k < 30; k++) begin
      rv.f = ($urandom_range(0, 1) == 0) ? GA_ADD : GA_SUB;
      rv.a = rnd_mv(); rv.b = rnd_mv();
      rv.stall = $urandom_range(0, 3);
      rv.delay = $urandom_range(0, 5);
      rv.hold = $urandom_range(0, 2);
      rv.er = ($urandom_range(0, 3) == 0);
      rv.ov = ($urandom_range(0, 5) == 0);
      rv.un = ($urandom_range(0, 5) == 0);
      rv.exp_r = model_op(rv.f, rv.a, rv.b);
      rv.exp_e = rv.er | rv.ov | rv.un;
      run_txn(rv);
    end

`ifdef GA_ISSUE_TIMEOUT_EN
    // no response: DONE after 8 WAIT cycles
    start_txn(GA_ADD, mv(GA_ONE, 0, 0), mv(GA_ONE, 0, 0), 0);
    for (int i = 0; i < 8; i++) begin
      chk("to_wait", wb_valid, 1'b0);
      @(negedge clk);
    end
    chk("to_valid", wb_valid, 1'b1);
    chk("to_flags", {wb_error, wb_timeout}, 2'b11);
    chk("to_result", wb_result, 128'd0);
    ga_resp.valid = 1'b1; ga_resp.result = rnd_mv();
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("late_ready", issue_ready, 1'b0);
    chk("late_ignored", {wb_valid, busy}, 2'b00);
    clr_resp();
    #1 chk("late_release", issue_ready, 1'b1);
    @(negedge clk);
    // response in the timeout cycle wins
    start_txn(GA_ADD, mv(GA_ONE, 0, 0), mv(GA_ONE, 0, 0), 0);
    for (int i = 0; i < 7; i++) @(negedge clk);
    respond(mv(16'h0200, 0, 0), 0, 0, 0);
    chk("race_valid", wb_valid, 1'b1);
    chk("race_flags", {wb_error, wb_timeout}, 2'b00);
    chk("race_result", wb_result, mv(16'h0200, 0, 0));
    consume();
`else
    // without the timeout WAIT must stay put
    start_txn(GA_ADD, mv(GA_ONE, 0, 0), mv(GA_ONE, 0, 0), 0);
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("nto_wait", {wb_valid, busy, wb_timeout}, 3'b010);
    respond(mv(16'h0200, 0, 0), 0, 0, 0);
    chk("nto_result", wb_result, mv(16'h0200, 0, 0));
    consume();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
